// File: rtl/xfer_cross_src_pkg.sv
// rtl/xfer_cross_src_pkg.sv - shared state type and default parameters for the toggle CDC source
package xfer_cross_src_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int DEFAULT_REGISTER = 2;
    localparam int DEFAULT_TIMEOUT  = 1024;

endpackage

// File: rtl/xfer_cross_src_ack_resync.sv
// rtl/xfer_cross_src_ack_resync.sv - multi-stage 1-bit resampler for the returning ack level
module ack_resync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/xfer_cross_src.sv
// rtl/xfer_cross_src.sv - source side of a two-phase toggle word crossing
// Optional ack watchdog built only when XFER_CROSS_SRC_TIMEOUT_EN is defined.
module xfer_cross_src
    import xfer_cross_src_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int REGISTER = DEFAULT_REGISTER,
    parameter int TIMEOUT  = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic [WIDTH-1:0] xfer_data,
    output logic             xfer_req,
    input  logic             xfer_ack,
    output logic             done,
    output logic             proto_err,
    output logic             timeout,
    input  logic             timeout_clr
);

    state_t state;
    logic   ack_s;

    ack_resync #(
        .STAGES (REGISTER)
    ) u_ack_resync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (xfer_ack),
        .q     (ack_s)
    );

    // ready is 1 exactly in IDLE, so valid alone qualifies an accept there
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready     <= 1'b1;
            xfer_req  <= 1'b0;
            xfer_data <= '0;
            done      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (ack_s != xfer_req) begin
                    proto_err <= 1'b1;
                end
                if (valid) begin
                    xfer_data <= data;
                    xfer_req  <= ~xfer_req;
                    ready     <= 1'b0;
                    state     <= WAIT;
                end
            end else begin
                if (ack_s == xfer_req) begin
                    done  <= 1'b1;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            end
        end
    end

`ifdef XFER_CROSS_SRC_TIMEOUT_EN
    localparam int             CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT);

    logic [CW-1:0] wait_cnt;
    logic          timeout_q;

    // Held at zero while idle so every WAIT starts counting from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == IDLE) begin
                wait_cnt <= '0;
            end else if (wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if ((state == WAIT) && (wait_cnt == CNT_MAX - 1'b1)) begin
                timeout_q <= 1'b1;
            end else if (timeout_clr) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_clr;

    assign unused_timeout_clr = timeout_clr;
    assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_xfer_cross_src.sv
// tb/tb_xfer_cross_src.sv - self-checking bench for xfer_cross_src
module tb_xfer_cross_src;

    localparam int WIDTH = 32;
    localparam int REG   = 2;
    localparam int TMO   = 16;
    localparam int NRND  = 12;
`ifdef XFER_CROSS_SRC_TIMEOUT_EN
    localparam logic TMO_ON = 1'b1;
`else
    localparam logic TMO_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             valid = 1'b0;
    logic [WIDTH-1:0] data = '0;
    logic             ready;
    logic [WIDTH-1:0] xfer_data;
    logic             xfer_req;
    logic             xfer_ack = 1'b0;
    logic             done;
    logic             proto_err;
    logic             timeout;
    logic             timeout_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    xfer_cross_src #(
        .WIDTH    (WIDTH),
        .REGISTER (REG),
        .TIMEOUT  (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid       (valid),
        .data        (data),
        .ready       (ready),
        .xfer_data   (xfer_data),
        .xfer_req    (xfer_req),
        .xfer_ack    (xfer_ack),
        .done        (done),
        .proto_err   (proto_err),
        .timeout     (timeout),
        .timeout_clr (timeout_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        data = '0;
        xfer_ack = 1'b0;
        timeout_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 6;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
        if (xfer_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", xfer_req); end
        if (xfer_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", xfer_data); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto got %b exp 0", proto_err); end
        if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout); end
    endtask

    // Accept at edge 5, ack 3 cycles after req rises, junk on valid/data throughout WAIT
    task automatic test_single_and_ignored();
        logic [WIDTH-1:0] w = 32'hA5A5_0001;
        int done_edge = 5 + 1 + 3 + REG;
        apply_reset();
        tick(4);
        valid = 1'b1;
        data = w;
        for (int e = 5; e <= done_edge + 1; e++) begin
            tick(1);
            valid = (e < done_edge);
            data = $urandom;
            if (e == 8) xfer_ack = 1'b1;
            checks += 4;
            if (xfer_data !== w) begin errors++; $display("FAIL single_data e=%0d got %h exp %h", e, xfer_data, w); end
            if (xfer_req !== 1'b1) begin errors++; $display("FAIL single_req e=%0d got %b exp 1", e, xfer_req); end
            if (done !== (e == done_edge)) begin errors++; $display("FAIL single_done e=%0d got %b exp %b", e, done, e == done_edge); end
            if (ready !== (e >= done_edge)) begin errors++; $display("FAIL single_ready e=%0d got %b exp %b", e, ready, e >= done_edge); end
        end
    endtask

    // Zero-delay echo: accepts every REG+2 edges, each in the cycle of the previous done
    task automatic test_back_to_back();
        logic [WIDTH-1:0] w [3];
        int per = REG + 2;
        int n_acc, n_done, n_tog;
        logic prev_req;
        logic [WIDTH-1:0] exp_data;
        w[0] = 32'h1; w[1] = 32'h2; w[2] = 32'h3;
        apply_reset();
        n_done = 0;
        n_tog = 0;
        prev_req = 1'b0;
        for (int e = 1; e <= 3 * per + 2; e++) begin
            n_acc = (e - 1 + per - 1) / per;
            if (n_acc > 3) n_acc = 3;
            valid = (n_acc < 3);
            data = (n_acc < 3) ? w[n_acc] : '0;
            tick(1);
            xfer_ack = xfer_req;
            n_acc = (e - 1) / per + 1;
            if (n_acc > 3) n_acc = 3;
            exp_data = w[n_acc - 1];
            if (done === 1'b1) n_done++;
            if (xfer_req !== prev_req) n_tog++;
            prev_req = xfer_req;
            checks += 3;
            if (done !== ((e % per == 0) && (e <= 3 * per))) begin errors++; $display("FAIL b2b_done e=%0d got %b", e, done); end
            if (xfer_req !== ((n_acc % 2) == 1)) begin errors++; $display("FAIL b2b_req e=%0d got %b exp %0d", e, xfer_req, n_acc % 2); end
            if (xfer_data !== exp_data) begin errors++; $display("FAIL b2b_data e=%0d got %h exp %h", e, xfer_data, exp_data); end
        end
        checks += 2;
        if (n_done != 3) begin errors++; $display("FAIL b2b_done_count got %0d exp 3", n_done); end
        if (n_tog != 3) begin errors++; $display("FAIL b2b_toggle_count got %0d exp 3", n_tog); end
    endtask

    task automatic test_proto_err();
        apply_reset();
        tick(2);
        xfer_ack = 1'b1;
        for (int k = 1; k <= REG + 1; k++) begin
            tick(1);
            checks++;
            if (proto_err !== (k == REG + 1)) begin errors++; $display("FAIL proto_set k=%0d got %b exp %b", k, proto_err, k == REG + 1); end
        end
        xfer_ack = 1'b0;
        tick(6);
        checks++;
        if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky got %b exp 1", proto_err); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_reset got %b exp 0", proto_err); end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        valid = 1'b1;
        data = $urandom | 32'h1;
        tick(1);
        valid = 1'b0;
        tick(1);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL midwait_busy got %b exp 0", ready); end
        rst_n = 1'b0;
        #2;
        checks += 4;
        if (xfer_req !== 1'b0) begin errors++; $display("FAIL midwait_req got %b exp 0", xfer_req); end
        if (xfer_data !== '0) begin errors++; $display("FAIL midwait_data got %h exp 0", xfer_data); end
        if (ready !== 1'b1) begin errors++; $display("FAIL midwait_ready got %b exp 1", ready); end
        if (done !== 1'b0) begin errors++; $display("FAIL midwait_done got %b exp 0", done); end
    endtask

    // Accept at edge 1; expiry at edge 1+TMO coincides with a clear request
    task automatic test_timeout();
        int exp_edge = 1 + TMO;
        apply_reset();
        valid = 1'b1;
        data = $urandom;
        tick(1);
        valid = 1'b0;
        for (int e = 2; e <= exp_edge + 3; e++) begin
            timeout_clr = (e == exp_edge);
            tick(1);
            checks++;
            if (timeout !== (TMO_ON && e >= exp_edge)) begin errors++; $display("FAIL tmo_expire e=%0d got %b exp %b", e, timeout, TMO_ON && e >= exp_edge); end
        end
        timeout_clr = 1'b0;
        xfer_ack = 1'b1;
        tick(REG + 1);
        checks += 2;
        if (done !== 1'b1) begin errors++; $display("FAIL tmo_late_done got %b exp 1", done); end
        if (timeout !== TMO_ON) begin errors++; $display("FAIL tmo_hold got %b exp %b", timeout, TMO_ON); end
        timeout_clr = 1'b1;
        tick(1);
        timeout_clr = 1'b0;
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear got %b exp 0", timeout); end
    endtask

    // Schedule model: accept A, done at A+1+delay+REG, next accept after a random idle gap
    task automatic test_random_stream();
        int acc [NRND];
        int dn  [NRND];
        int dl  [NRND];
        logic [WIDTH-1:0] w [NRND];
        int t, last, nacc;
        logic exp_ready, exp_done;
        logic [WIDTH-1:0] exp_data;
        apply_reset();
        t = 0;
        for (int i = 0; i < NRND; i++) begin
            acc[i] = t + 1 + $urandom_range(0, 2);
            dl[i] = $urandom_range(0, 4);
            dn[i] = acc[i] + 1 + dl[i] + REG;
            w[i] = $urandom;
            t = dn[i];
        end
        last = dn[NRND-1] + 2;
        for (int e = 1; e <= last; e++) begin
            valid = 1'b0;
            data = $urandom;
            for (int i = 0; i < NRND; i++) begin
                if (acc[i] == e) begin
                    valid = 1'b1;
                    data = w[i];
                end else if (e > acc[i] && e <= dn[i]) begin
                    valid = 1'($urandom_range(0, 1));
                end
            end
            tick(1);
            for (int i = 0; i < NRND; i++) begin
                if (acc[i] + dl[i] == e) xfer_ack = ((i + 1) % 2) == 1;
            end
            nacc = 0;
            exp_ready = 1'b1;
            exp_done = 1'b0;
            exp_data = '0;
            for (int i = 0; i < NRND; i++) begin
                if (acc[i] <= e) begin
                    nacc++;
                    exp_data = w[i];
                end
                if (acc[i] <= e && e < dn[i]) exp_ready = 1'b0;
                if (dn[i] == e) exp_done = 1'b1;
            end
            checks += 5;
            if (ready !== exp_ready) begin errors++; $display("FAIL rnd_ready e=%0d got %b exp %b", e, ready, exp_ready); end
            if (done !== exp_done) begin errors++; $display("FAIL rnd_done e=%0d got %b exp %b", e, done, exp_done); end
            if (xfer_req !== ((nacc % 2) == 1)) begin errors++; $display("FAIL rnd_req e=%0d got %b exp %0d", e, xfer_req, nacc % 2); end
            if (xfer_data !== exp_data) begin errors++; $display("FAIL rnd_data e=%0d got %h exp %h", e, xfer_data, exp_data); end
            if (proto_err !== 1'b0) begin errors++; $display("FAIL rnd_proto e=%0d got %b exp 0", e, proto_err); end
        end
    endtask

    initial begin
        test_reset();
        test_single_and_ignored();
        test_back_to_back();
        test_proto_err();
        test_reset_mid_wait();
        test_timeout();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
